// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline (X operand register -> W result register)
// with valid/ready flow control, flush, bypass-match output and result counter.

// Pure combinational 16-bit ALU used between the X and W registers.
module alu16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  output logic [15:0] r,
  output logic        zero,
  output logic        ovfl
);
  logic [16:0] w_sum;
  logic [14:0] w_lo_shr;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_lo_shr = a[14:0] >> b;

  always_comb begin
    r = 16'h0000;
    case (op)
      3'b000: r = w_sum[15:0];
      3'b001: r = a - b;
      3'b010: r = a | b;
      3'b011: r = a & b;
      3'b100: r = a << b;
      3'b101: r = a >> b;
      3'b110: r = {a[15], w_lo_shr};
      3'b111: r = a;
      default: r = 16'h0000;
    endcase
  end

  // Carry-out of the unsigned add, reported for every opcode.
  assign ovfl = w_sum[16];
  assign zero = (r == 16'h0000);
endmodule

// Handshake: a stage transfers on a rising clk edge when valid & ready are both
// high; out_valid and the W payload hold stable until out_ready is seen.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic        in_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        out_zero,
  output logic        out_ovfl,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output logic        fwd_hit_a,
  input  logic [3:0]  fwd_src_a,
  output logic [15:0] op_count
);
  logic        r_x_valid;
  logic [15:0] r_x_a;
  logic [15:0] r_x_b;
  logic [2:0]  r_x_op;
  logic [3:0]  r_x_rd;
  logic        r_x_we;

  logic        r_w_valid;
  logic [15:0] r_w_r;
  logic        r_w_zero;
  logic        r_w_ovfl;
  logic [3:0]  r_w_rd;
  logic        r_w_we;
  logic [15:0] r_op_count;

  logic        w_adv_w;
  logic        w_adv_x;
  logic        w_xfer_out;
  logic [15:0] w_alu_r;
  logic        w_alu_zero;
  logic        w_alu_ovfl;

  alu16b u_alu (
    .a    (r_x_a),
    .b    (r_x_b),
    .op   (r_x_op),
    .r    (w_alu_r),
    .zero (w_alu_zero),
    .ovfl (w_alu_ovfl)
  );

  assign w_adv_w    = !r_w_valid | out_ready;
  assign w_adv_x    = !r_x_valid | w_adv_w;
  assign w_xfer_out = r_w_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_valid  <= 1'b0;
      r_x_a      <= 16'h0000;
      r_x_b      <= 16'h0000;
      r_x_op     <= 3'b000;
      r_x_rd     <= 4'h0;
      r_x_we     <= 1'b0;
      r_w_valid  <= 1'b0;
      r_w_r      <= 16'h0000;
      r_w_zero   <= 1'b1;
      r_w_ovfl   <= 1'b0;
      r_w_rd     <= 4'h0;
      r_w_we     <= 1'b0;
      r_op_count <= 16'h0000;
    end else begin
      // A result leaving in a flush cycle was already delivered, so it counts.
      if (w_xfer_out) r_op_count <= r_op_count + 16'h0001;
      if (flush) begin
        r_x_valid <= 1'b0;
        r_w_valid <= 1'b0;
      end else begin
        if (w_adv_x) begin
          r_x_valid <= in_valid;
          r_x_a     <= in_a;
          r_x_b     <= in_b;
          r_x_op    <= in_op;
          r_x_rd    <= in_rd;
          r_x_we    <= in_we;
        end
        if (w_adv_w) begin
          r_w_valid <= r_x_valid;
          r_w_r     <= w_alu_r;
          r_w_zero  <= w_alu_zero;
          r_w_ovfl  <= w_alu_ovfl;
          r_w_rd    <= r_x_rd;
          r_w_we    <= r_x_we;
        end
      end
    end
  end

  assign in_ready  = w_adv_x;
  assign out_valid = r_w_valid;
  assign out_r     = r_w_r;
  assign out_zero  = r_w_zero;
  assign out_ovfl  = r_w_ovfl;
  assign out_rd    = r_w_rd;
  assign out_we    = r_w_we;
  assign op_count  = r_op_count;
  assign fwd_hit_a = r_w_valid & r_w_we & (r_w_rd == fwd_src_a);
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: inputs change 1ns after the rising edge,
// outputs are checked at that same point, before the next edge.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_we, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_r, op_count;
  logic [2:0]  in_op;
  logic [3:0]  in_rd, out_rd, fwd_src_a;
  logic        out_zero, out_ovfl, out_we, fwd_hit_a;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;
  int guard;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_ovfl(out_ovfl),
    .out_rd(out_rd), .out_we(out_we),
    .fwd_hit_a(fwd_hit_a), .fwd_src_a(fwd_src_a), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [3:0] rd, input logic we);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_rd = rd; in_we = we;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'h0000);
    chk({tag, "_r"},     out_r,              16'h0000);
    chk({tag, "_zero"},  {15'd0, out_zero},  16'h0001);
    chk({tag, "_ovfl"},  {15'd0, out_ovfl},  16'h0000);
    chk({tag, "_rd"},    {12'd0, out_rd},    16'h0000);
    chk({tag, "_we"},    {15'd0, out_we},    16'h0000);
    chk({tag, "_cnt"},   op_count,           16'h0000);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_rd = '0; in_we = 1'b0; fwd_src_a = '0;
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();
    chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);

    // Single add, two-cycle latency
    out_ready = 1'b1;
    issue(16'h0003, 16'h0004, 3'b000, 4'd5, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("add_valid", {15'd0, out_valid}, 16'h0001);
    chk("add_r",     out_r,              16'h0007);
    chk("add_zero",  {15'd0, out_zero},  16'h0000);
    chk("add_ovfl",  {15'd0, out_ovfl},  16'h0000);
    chk("add_rd",    {12'd0, out_rd},    16'h0005);
    step();
    chk("add_cnt",   op_count,           16'h0001);
    chk("add_drain", {15'd0, out_valid}, 16'h0000);

    // Carry-out and zero flag; carry reported even for AND
    issue(16'hFFFF, 16'h0001, 3'b000, 4'd1, 1'b1);
    step();
    issue(16'hFFFF, 16'h0001, 3'b011, 4'd2, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ovf_add_r",    out_r,             16'h0000);
    chk("ovf_add_zero", {15'd0, out_zero}, 16'h0001);
    chk("ovf_add_ovfl", {15'd0, out_ovfl}, 16'h0001);
    step();
    chk("ovf_and_r",    out_r,             16'h0001);
    chk("ovf_and_zero", {15'd0, out_zero}, 16'h0000);
    chk("ovf_and_ovfl", {15'd0, out_ovfl}, 16'h0001);
    step();

    // Shifts, full throughput
    issue(16'h8010, 16'h0002, 3'b110, 4'd4, 1'b1);
    step();
    issue(16'h8010, 16'h0002, 3'b101, 4'd4, 1'b1);
    step();
    chk("sh_ashr", out_r, 16'h8004);
    issue(16'h8010, 16'h0002, 3'b100, 4'd4, 1'b1);
    step();
    chk("sh_lshr", out_r, 16'h2004);
    in_valid = 1'b0;
    step();
    chk("sh_shl", out_r, 16'h0040);
    step();
    chk("sh_cnt", op_count, 16'h0006);

    // Backpressure: three ops, downstream stalled
    out_ready = 1'b0;
    issue(16'h0001, 16'h0001, 3'b000, 4'd1, 1'b1);
    step();
    issue(16'h000A, 16'h0003, 3'b001, 4'd2, 1'b1);
    chk("bp_rdy2", {15'd0, in_ready}, 16'h0001);
    step();
    issue(16'h00F0, 16'h000F, 3'b010, 4'd3, 1'b1);
    chk("bp_rdy3", {15'd0, in_ready}, 16'h0000);
    step();
    chk("bp_hold_r1", out_r,              16'h0002);
    chk("bp_hold_v1", {15'd0, out_valid}, 16'h0001);
    step();
    chk("bp_hold_r2", out_r,              16'h0002);
    chk("bp_hold_rd", {12'd0, out_rd},    16'h0001);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", {15'd0, in_ready},  16'h0001);
    step();
    in_valid = 1'b0;
    chk("bp_res2_r",  out_r,              16'h0007);
    chk("bp_res2_rd", {12'd0, out_rd},    16'h0002);
    step();
    chk("bp_res3_r",  out_r,              16'h00FF);
    chk("bp_res3_rd", {12'd0, out_rd},    16'h0003);
    step();
    chk("bp_cnt",     op_count,           16'h0009);
    chk("bp_drain",   {15'd0, out_valid}, 16'h0000);

    // Flush with two ops in flight and a capture offered in the same cycle
    out_ready = 1'b0;
    issue(16'h0011, 16'h0022, 3'b000, 4'd6, 1'b1);
    step();
    issue(16'h0033, 16'h0044, 3'b000, 4'd7, 1'b1);
    step();
    issue(16'h0055, 16'h0066, 3'b000, 4'd8, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid0", {15'd0, out_valid}, 16'h0000);
    chk("fl_cnt0",   op_count,           16'h0009);
    step();
    chk("fl_valid1", {15'd0, out_valid}, 16'h0000);
    step();
    chk("fl_valid2", {15'd0, out_valid}, 16'h0000);
    chk("fl_cnt2",   op_count,           16'h0009);

    // A transfer out in the flush cycle still counts
    out_ready = 1'b0;
    issue(16'h0001, 16'h0002, 3'b000, 4'd9, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flx_cnt",   op_count,           16'h000A);
    chk("flx_valid", {15'd0, out_valid}, 16'h0000);

    // Reset mid-operation beats flush and handshakes
    issue(16'h1234, 16'h0001, 3'b000, 4'd7, 1'b1);
    step();
    issue(16'h4321, 16'h0001, 3'b000, 4'd8, 1'b1);
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk_reset_vals("mrst");
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("mrst_rdy",    {15'd0, in_ready},  16'h0001);
    chk("mrst_valid1", {15'd0, out_valid}, 16'h0000);
    step();
    chk("mrst_valid2", {15'd0, out_valid}, 16'h0000);

    // Bypass match
    out_ready = 1'b0; fwd_src_a = 4'd3;
    #1;
    chk("fwd_idle", {15'd0, fwd_hit_a}, 16'h0000);
    issue(16'h0000, 16'h0000, 3'b000, 4'd3, 1'b1);
    step();
    issue(16'h0000, 16'h0000, 3'b000, 4'd3, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fwd_hit", {15'd0, fwd_hit_a}, 16'h0001);
    fwd_src_a = 4'd4;
    #1;
    chk("fwd_miss_idx", {15'd0, fwd_hit_a}, 16'h0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; fwd_src_a = 4'd3;
    #1;
    chk("fwd_we0_we",   {15'd0, out_we},    16'h0000);
    chk("fwd_miss_we0", {15'd0, fwd_hit_a}, 16'h0000);
    out_ready = 1'b1;
    step();
    chk("fwd_cnt", op_count, 16'h0002);

    // Stream until 0xFFFF results accepted, then one more wraps to 0
    exp_cnt = 16'h0002;
    guard = 0;
    issue(16'h0000, 16'h0000, 3'b111, 4'd0, 1'b0);
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      if (out_valid && out_ready) exp_cnt = exp_cnt + 16'h0001;
      step();
      guard++;
    end
    chk("wrap_budget", (guard < 70000) ? 16'h0001 : 16'h0000, 16'h0001);
    chk("wrap_ffff",   op_count,           16'hFFFF);
    chk("wrap_valid",  {15'd0, out_valid}, 16'h0001);
    step();
    in_valid = 1'b0;
    chk("wrap_zero",   op_count,           16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
